nv_gated_counter: RTL
=====================

Name: nv_gated_counter

Overview:
Multi-channel gated photon-click counter for the NV controller. Each asynchronous detector click line is synchronised into the clk domain and rising-edge detected. Edges are counted per channel during a programmable gate window that opens on a start pulse. At gate close, all channel counts are latched into stable result registers and a one-cycle done pulse is issued to the sequencer/readout logic.

Parameters:
N_CH, 2, number of independent click channels
CNT_W, 16, width of each channel count; counters saturate at 2^CNT_W-1
GATE_W, 24, width of gate_len (gate length in clk cycles)
SYNC_STAGES, 2, flip-flop stages in each click synchroniser (minimum 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
click  input  N_CH  asynchronous detector pulses, one bit per channel
start  input  1  single-cycle request to open a gate; honoured only in IDLE
abort  input  1  terminates an open gate with no result update
gate_len  input  GATE_W  gate length in cycles; sampled on accepted start
busy  output  1  high from the cycle after an accepted start until done/abort
done  output  1  one-cycle pulse; results valid from this cycle on
counts  output  N_CH*CNT_W  latched results, channel i at [i*CNT_W +: CNT_W]
overflow  output  N_CH  latched per-channel saturation flags

Behaviour:
- Reset (synchronous, active-high clk, i.e. reset sampled on posedge clk): state=IDLE; busy=0, done=0, counts=0, overflow=0; live counters, gate timer and synchroniser flops cleared. Reset mid-gate discards the gate silently, with no done.
- Click path, per channel:
  - SYNC_STAGES-flop synchroniser, then a rising-edge detector giving a 1-cycle pulse.
  - Fixed latency SYNC_STAGES+1 cycles, not compensated.
  - Click high and low phases must each last at least 2 clk periods. Faster clicks may be missed, by design.
- FSM states: IDLE, ARM, COUNT, LATCH.
- IDLE: start=1 → ARM. gate_len is captured into the timer, and busy rises next cycle.
- ARM (1 cycle): clear live counters and live overflow.
  - Timer==0 → LATCH.
  - Otherwise → COUNT.
- COUNT: lasts exactly the captured gate_len cycles.
  - An edge pulse increments a channel only in COUNT cycles. Edges in IDLE, ARM or LATCH are ignored.
  - Counter at 2^CNT_W-1 holds its value and sets the live overflow bit.
  - Timer decrements each cycle; after the last COUNT cycle → LATCH.
- LATCH (1 cycle):
  - counts and overflow load from the live values; done=1; busy=0 in this same cycle.
  - Next state IDLE. A start in LATCH is ignored.
- abort:
  - In ARM or COUNT: → IDLE next cycle, busy=0, no done, counts/overflow unchanged.
  - In IDLE or LATCH: ignored.
  - abort has priority over the gate expiring on the same cycle.
- start while busy: ignored, with no queueing.
- gate_len changes while busy: no effect.
- counts/overflow hold their values until the next LATCH; they are never cleared except by reset.
- Total start-to-done latency: gate_len+2 cycles (ARM + COUNT×gate_len + LATCH).

Decomposition:
- Package nv_ctrl_pkg holds:
  - the state enum (IDLE/ARM/COUNT/LATCH);
  - default constants for N_CH, CNT_W, GATE_W, SYNC_STAGES;
  - a helper function for the channel slice offset.
- Sub-module nv_click_sync (parameter SYNC_STAGES; ports clk, reset, async_in, edge_pulse) is instantiated once per channel.
- Counters, timer and FSM are kept in nv_gated_counter.

Test Plan:
- Basic gate: reset, then gate_len=100, start; ch0 gets 7 clicks and ch1 gets 3, all well inside the window (each 4 cycles high / 4 low) → done exactly 102 cycles after start, counts ch0=7, ch1=3, overflow=00, busy high for 101 cycles.
- Window edges: clicks whose synchronised edge lands 1 cycle before the first COUNT cycle and 1 cycle after the last → not counted. Clicks landing on the first and last COUNT cycles → counted, giving 2.
- Saturation: CNT_W=4, 20 clicks on ch0 in gate_len=200 → counts ch0=15, overflow[0]=1, overflow[1]=0. A following gate with 2 clicks → ch0=2, overflow=00.
- Zero gate / ignored start: gate_len=0 → done 2 cycles after start, counts all 0. A start pulsed while busy during a gate_len=50 run → exactly one done.
- Abort: gate_len=100 with 5 clicks, abort at COUNT cycle 40 → no done, busy low next cycle, counts keep the previous results. A fresh start then completes normally.
- Reset mid-gate: reset asserted during COUNT → all outputs 0 next cycle, no done pulse, state IDLE. A subsequent start works normally.

Source files
------------

// File: rtl/nv_ctrl_pkg.sv
// Shared types and defaults for the NV controller gated photon counter.
package nv_ctrl_pkg;

  localparam int N_CH_DEF        = 2;
  localparam int CNT_W_DEF       = 16;
  localparam int GATE_W_DEF      = 24;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    LATCH = 2'd3
  } state_e;

  // Bit offset of channel ch inside a flattened per-channel bus of width w.
  function automatic int ch_offset(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/nv_click_sync.sv
// Click synchroniser: brings one asynchronous detector line into the clk
// domain and emits a single-cycle pulse on each rising edge.
module nv_click_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus one flop of history for the edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/nv_gated_counter.sv
// Multi-channel gated photon-click counter. A start opens a gate of
// gate_len cycles; clicks seen during the gate are counted per channel
// (saturating), then latched into result registers with a done pulse.
module nv_gated_counter
  import nv_ctrl_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int GATE_W      = GATE_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        click,
  input  logic                   start,
  input  logic                   abort,
  input  logic [GATE_W-1:0]      gate_len,
  output logic                   busy,
  output logic                   done,
  output logic [N_CH*CNT_W-1:0]  counts,
  output logic [N_CH-1:0]        overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                        state_q, state_d;
  logic [GATE_W-1:0]             timer_q, timer_d;
  logic [N_CH-1:0][CNT_W-1:0]    live_q, live_d;
  logic [N_CH-1:0]               lovf_q, lovf_d;
  logic [N_CH*CNT_W-1:0]         counts_q, counts_d;
  logic [N_CH-1:0]               ovf_q, ovf_d;
  logic [N_CH-1:0]               edge_pulse;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    nv_click_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .async_in  (click[i]),
      .edge_pulse(edge_pulse[i])
    );
  end

  // Next-state logic: gate sequencing, live counting and result capture.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    live_d   = live_q;
    lovf_d   = lovf_q;
    counts_d = counts_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          timer_d = gate_len;
        end
      end

      ARM: begin
        live_d = '0;
        lovf_d = '0;
        if (abort) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          state_d = LATCH;
        end else begin
          state_d = COUNT;
        end
      end

      COUNT: begin
        for (int i = 0; i < N_CH; i++) begin
          if (edge_pulse[i]) begin
            if (live_q[i] == CNT_MAX) begin
              lovf_d[i] = 1'b1;
            end else begin
              live_d[i] = live_q[i] + CNT_W'(1);
            end
          end
        end
        timer_d = timer_q - GATE_W'(1);
        // abort wins over the gate expiring in the same cycle
        if (abort) begin
          state_d = IDLE;
        end else if (timer_q == GATE_W'(1)) begin
          state_d = LATCH;
        end
      end

      LATCH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Results are loaded on the edge entering LATCH so they are already
    // valid in the cycle that done is high; live_d includes the final
    // COUNT cycle's increments.
    if (state_d == LATCH) begin
      for (int i = 0; i < N_CH; i++) begin
        counts_d[ch_offset(i, CNT_W) +: CNT_W] = live_d[i];
      end
      ovf_d = lovf_d;
    end
  end

  // State, timer, live counters and latched results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      live_q   <= '0;
      lovf_q   <= '0;
      counts_q <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      live_q   <= live_d;
      lovf_q   <= lovf_d;
      counts_q <= counts_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == ARM) || (state_q == COUNT);
  assign done     = (state_q == LATCH);
  assign counts   = counts_q;
  assign overflow = ovf_q;

endmodule
